// File: rtl/uart_rx_if.sv
// Serial receive line plus byte handshake between the UART receiver
// and its consumer.
interface uart_rx_if;
  logic       Rx_i;
  logic       ack_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output Rx_i,
    output ack_i,
    input  data_o,
    input  valid_o,
    input  busy_o,
    input  frame_err_o,
    input  overrun_o
  );

  modport slave (
    input  Rx_i,
    input  ack_i,
    output data_o,
    output valid_o,
    output busy_o,
    output frame_err_o,
    output overrun_o
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling FSM,
// single-entry output holding register with overrun and framing flags.
module uart_rx #(
  parameter logic [15:0] BIT_CYCLES  = 16'd5210,
  parameter logic [15:0] HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic clk,
  input  logic rst,
  uart_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_m_q, rx_s_q, rx_d_q;
  logic        deliver;
  logic        bit_tick;

  // Synchronizer flops reset high so release never fakes a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= bus.Rx_i;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bit_tick = (cnt_q == BIT_CYCLES - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CYCLES - 16'd1) begin
          cnt_d = 16'd0;
          idx_d = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d = 16'd0;
          shift_d[idx_q] = rx_s_q;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          deliver = rx_s_q;
          ferr_d  = !rx_s_q;
        end
      end
    endcase
  end

  // A same-cycle ack frees the holding register for the new byte
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (deliver && (!valid_q || bus.ack_i)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q) ovr_d = 1'b0;
    end else if (deliver) begin
      ovr_d = 1'b1;
    end else if (bus.ack_i && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.frame_err_o = ferr_q;
  assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 cycles per bit, with directed
// scenarios and a randomized frame stream against a byte-level model.
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  // Rx_i falls at a negedge; valid_o is seen after this many posedges
  localparam int LAT  = 2 + HALF + 9 * BIT + 1;

  logic clk = 1'b0;
  logic rst;
  int   vec = 0;
  int   err = 0;
  int   ferr_cycles = 0;

  uart_rx_if bus ();

  uart_rx #(
    .BIT_CYCLES (16'd16),
    .HALF_CYCLES(16'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_err_o === 1'b1) ferr_cycles++;

  // Caller must be at a negedge; leaves Rx_i at the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    bus.Rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.Rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.Rx_i = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.Rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.Rx_i = 1'b1;
    bus.ack_i = 1'b0;
    #1;
    vec++;
    if ({bus.data_o, bus.valid_o, bus.busy_o, bus.frame_err_o,
         bus.overrun_o} !== 12'h000) begin
      err++;
      $display("FAIL reset_outputs got %h exp 000",
               {bus.data_o, bus.valid_o, bus.busy_o,
                bus.frame_err_o, bus.overrun_o});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(4);
    vec++;
    if (bus.busy_o !== 1'b0) begin
      err++;
      $display("FAIL reset_idle busy got %b exp 0", bus.busy_o);
    end
  endtask

  task automatic test_basic();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1;
        vec++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
          err++;
          $display("FAIL basic_early valid %b busy %b exp 0 1",
                   bus.valid_o, bus.busy_o);
        end
        @(posedge clk);
        #1;
        vec++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== 8'hA5) begin
          err++;
          $display("FAIL basic_latency valid %b data %h exp 1 a5",
                   bus.valid_o, bus.data_o);
        end
      end
    join
    idle(2);
    vec++;
    if (bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      err++;
      $display("FAIL basic_after busy %b ovr %b exp 0 0",
               bus.busy_o, bus.overrun_o);
    end
    pulse_ack();
    @(negedge clk);
    vec++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== 8'hA5) begin
      err++;
      $display("FAIL basic_ack valid %b data %h exp 0 a5",
               bus.valid_o, bus.data_o);
    end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cycles;
    bus.Rx_i = 1'b0;
    repeat (3) @(negedge clk);
    idle(6);
    vec++;
    if (bus.busy_o !== 1'b1) begin
      err++;
      $display("FAIL glitch_start busy got %b exp 1", bus.busy_o);
    end
    idle(20);
    vec++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 ||
        ferr_cycles != f0) begin
      err++;
      $display("FAIL glitch busy %b valid %b ferr %0d exp 0 0 0",
               bus.busy_o, bus.valid_o, ferr_cycles - f0);
    end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    vec++;
    if (ferr_cycles - f0 != 1 || bus.valid_o !== 1'b0 ||
        bus.data_o !== 8'hA5 || bus.busy_o !== 1'b0) begin
      err++;
      $display("FAIL frame_err pulses %0d valid %b data %h busy %b exp 1 0 a5 0",
               ferr_cycles - f0, bus.valid_o, bus.data_o, bus.busy_o);
    end
    idle(20);
    vec++;
    if (bus.busy_o !== 1'b0 || ferr_cycles - f0 != 1) begin
      err++;
      $display("FAIL break_release busy %b pulses %0d exp 0 1",
               bus.busy_o, ferr_cycles - f0);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    vec++;
    if (bus.data_o !== 8'h11 || bus.valid_o !== 1'b1 ||
        bus.overrun_o !== 1'b1) begin
      err++;
      $display("FAIL overrun data %h valid %b ovr %b exp 11 1 1",
               bus.data_o, bus.valid_o, bus.overrun_o);
    end
    pulse_ack();
    vec++;
    if (bus.valid_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      err++;
      $display("FAIL overrun_ack valid %b ovr %b exp 0 0",
               bus.valid_o, bus.overrun_o);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        pulse_ack();
      end
    join
    idle(4);
    vec++;
    if (bus.data_o !== 8'h22 || bus.valid_o !== 1'b1 ||
        bus.overrun_o !== 1'b0) begin
      err++;
      $display("FAIL b2b_ack data %h valid %b ovr %b exp 22 1 0",
               bus.data_o, bus.valid_o, bus.overrun_o);
    end
  endtask

  task automatic test_mid_reset();
    int f0;
    f0 = ferr_cycles;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * BIT + 8) @(negedge clk);
        rst = 1'b0;
        #1;
        vec++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== 8'h00 ||
            bus.busy_o !== 1'b0) begin
          err++;
          $display("FAIL mid_reset valid %b data %h busy %b exp 0 00 0",
                   bus.valid_o, bus.data_o, bus.busy_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    join
    idle(30);
    vec++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        ferr_cycles != f0) begin
      err++;
      $display("FAIL post_reset valid %b busy %b ferr %0d exp 0 0 0",
               bus.valid_o, bus.busy_o, ferr_cycles - f0);
    end
    send_frame(8'h5A, 1'b1);
    idle(2);
    vec++;
    if (bus.data_o !== 8'h5A || bus.valid_o !== 1'b1 ||
        bus.overrun_o !== 1'b0) begin
      err++;
      $display("FAIL after_reset data %h valid %b ovr %b exp 5a 1 0",
               bus.data_o, bus.valid_o, bus.overrun_o);
    end
    pulse_ack();
  endtask

  task automatic test_random();
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    int         m_ferr;
    logic [7:0] b;
    logic       stop;
    logic       do_ack;
    int         gap;
    m_data  = bus.data_o;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = ferr_cycles;
    for (int n = 0; n < 16; n++) begin
      b      = 8'($urandom);
      stop   = ($urandom_range(0, 5) != 0);
      do_ack = ($urandom_range(0, 2) != 0);
      gap    = $urandom_range(0, 12);
      send_frame(b, stop);
      if (!stop) begin
        gap = gap + 2;
        m_ferr++;
      end else if (!m_valid) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      vec++;
      if (bus.data_o !== m_data || bus.valid_o !== m_valid ||
          bus.overrun_o !== m_ovr || ferr_cycles != m_ferr) begin
        err++;
        $display("FAIL rand_%0d data %h valid %b ovr %b ferr %0d exp %h %b %b %0d",
                 n, bus.data_o, bus.valid_o, bus.overrun_o, ferr_cycles,
                 m_data, m_valid, m_ovr, m_ferr);
      end
      if (do_ack) begin
        bus.Rx_i = 1'b1;
        pulse_ack();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      if (gap > 0) idle(gap);
      else bus.Rx_i = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
